// File: rtl/kv_table.sv
// Direct-mapped flow status table: keys fold to an index, and each entry holds a status plus a one-bit age.
// A three-stage pipeline does the lookup and write-back, and a periodic aging tick evicts idle entries.
module kv_table #(
   parameter int KEY_SIZE   = 96,
   parameter int TABLE_BITS = 4,
   parameter int AGE_CYCLES = 156250000
) (
   input  logic                clk156,
   input  logic                eth_rst,
   input  logic [KEY_SIZE-1:0] in_key,
   input  logic [3:0]          in_flag,
   input  logic                in_valid,
   output logic                out_valid,
   output logic [3:0]          out_flag,
   output logic [7:0]          debug
);

   localparam int ENTRIES = 2 ** TABLE_BITS;
   localparam int SLICES  = KEY_SIZE / TABLE_BITS;
   localparam int AGE_W   = (AGE_CYCLES > 1) ? $clog2(AGE_CYCLES) : 1;

   function automatic logic [TABLE_BITS-1:0] fold_index(input logic [KEY_SIZE-1:0] key);
      logic [TABLE_BITS-1:0] idx;
      idx = '0;
      for (int i = 0; i < SLICES; i++) idx ^= key[i*TABLE_BITS +: TABLE_BITS];
      return idx;
   endfunction

   logic                  ent_valid  [ENTRIES];
   logic [KEY_SIZE-1:0]   ent_tag    [ENTRIES];
   logic [1:0]            ent_status [ENTRIES];
   logic                  ent_age    [ENTRIES];

   logic                  s0_valid, s1_valid;
   logic [KEY_SIZE-1:0]   s0_key, s1_key;
   logic [2:0]            s0_op, s1_op;
   logic [TABLE_BITS-1:0] s0_index, s1_index;
   logic                  s1_hit, s1_occupied;
   logic [1:0]            s1_status;

   logic                  rd_valid;
   logic [KEY_SIZE-1:0]   rd_tag;
   logic [1:0]            rd_status;

   logic                  wr_en, wr_valid, resp_hit, collision;
   logic [1:0]            wr_status, resp_status;

   logic [AGE_W-1:0]      age_cnt;
   logic                  age_tick;
   logic [3:0]            hit_cnt, collision_cnt;

   assign age_tick = (age_cnt == AGE_W'(AGE_CYCLES - 1));
   assign debug    = {collision_cnt, hit_cnt};

   // An S1 read of the slot that S2 writes this cycle takes the new data, so same-key requests stay in order.
   always_comb begin
      rd_valid  = ent_valid[s0_index];
      rd_tag    = ent_tag[s0_index];
      rd_status = ent_status[s0_index];
      if (wr_en && (s1_index == s0_index)) begin
         rd_valid  = wr_valid;
         rd_tag    = s1_key;
         rd_status = wr_status;
      end
   end

   always_comb begin
      wr_en       = 1'b0;
      wr_valid    = 1'b0;
      wr_status   = s1_status;
      resp_hit    = 1'b0;
      resp_status = 2'b00;
      collision   = 1'b0;
      if (s1_valid) begin
         if (s1_op[2]) begin
            if (s1_hit) begin
               wr_en    = 1'b1;
               resp_hit = 1'b1;
            end
         end else begin
            case (s1_op[1:0])
               2'b01: begin
                  wr_en    = 1'b1;
                  wr_valid = 1'b1;
                  if (s1_hit) begin
                     resp_hit    = 1'b1;
                     resp_status = s1_status;
                  end else begin
                     wr_status   = 2'b01;
                     resp_status = 2'b01;
                     collision   = s1_occupied;
                  end
               end
               2'b10: begin
                  if (s1_hit) begin
                     wr_en       = 1'b1;
                     wr_valid    = 1'b1;
                     wr_status   = 2'b10;
                     resp_hit    = 1'b1;
                     resp_status = 2'b10;
                  end
               end
               default: begin
                  if (s1_hit) begin
                     wr_en       = 1'b1;
                     wr_valid    = 1'b1;
                     resp_hit    = 1'b1;
                     resp_status = s1_status;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk156) begin
      if (eth_rst) begin
         s0_valid      <= 1'b0;
         s0_key        <= '0;
         s0_op         <= '0;
         s0_index      <= '0;
         s1_valid      <= 1'b0;
         s1_key        <= '0;
         s1_op         <= '0;
         s1_index      <= '0;
         s1_hit        <= 1'b0;
         s1_occupied   <= 1'b0;
         s1_status     <= 2'b00;
         out_valid     <= 1'b0;
         out_flag      <= 4'b0000;
         hit_cnt       <= 4'd0;
         collision_cnt <= 4'd0;
         age_cnt       <= '0;
      end else begin
         s0_valid    <= in_valid && in_flag[0];
         s0_key      <= in_key;
         s0_op       <= in_flag[3:1];
         s0_index    <= fold_index(in_key);
         s1_valid    <= s0_valid;
         s1_key      <= s0_key;
         s1_op       <= s0_op;
         s1_index    <= s0_index;
         s1_hit      <= rd_valid && (rd_tag == s0_key);
         s1_occupied <= rd_valid;
         s1_status   <= rd_status;
         out_valid   <= s1_valid;
         out_flag    <= s1_valid ? {1'b0, resp_status, resp_hit} : 4'b0000;
         if (s1_valid && resp_hit) hit_cnt <= hit_cnt + 4'd1;
         if (collision) collision_cnt <= collision_cnt + 4'd1;
         age_cnt <= age_tick ? '0 : age_cnt + AGE_W'(1);
      end
   end

   // A write-back to an entry overrides the aging tick for that entry alone.
   always_ff @(posedge clk156) begin
      for (int i = 0; i < ENTRIES; i++) begin
         if (eth_rst) begin
            ent_valid[i]  <= 1'b0;
            ent_tag[i]    <= '0;
            ent_status[i] <= 2'b00;
            ent_age[i]    <= 1'b0;
         end else if (wr_en && (s1_index == TABLE_BITS'(i))) begin
            ent_valid[i]  <= wr_valid;
            ent_tag[i]    <= s1_key;
            ent_status[i] <= wr_status;
            ent_age[i]    <= 1'b0;
         end else if (age_tick && ent_valid[i]) begin
            if (ent_age[i]) ent_valid[i] <= 1'b0;
            else ent_age[i] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_kv_table.sv
// Directed bench for kv_table: each task drives one scenario and checks its responses against hand-computed values.
// The DUT uses an 8-cycle aging period so that eviction can be observed quickly.
module tb_kv_table;

   logic        clk156 = 1'b0;
   logic        eth_rst;
   logic [95:0] in_key;
   logic [3:0]  in_flag;
   logic        in_valid;
   logic        out_valid;
   logic [3:0]  out_flag;
   logic [7:0]  debug;

   int errors = 0;
   int checks = 0;

   localparam logic [95:0] K  = 96'h0A000001_0A000002_3039_0000;
   localparam logic [95:0] KC = 96'h0A000002_0A000001_3039_0000;
   localparam logic [95:0] K2 = 96'hC0A80001_C0A80002_0050_0000;

   localparam logic [3:0] F_SUSPECT = 4'b0011;
   localparam logic [3:0] F_ARREST  = 4'b0101;
   localparam logic [3:0] F_QUERY   = 4'b0001;
   localparam logic [3:0] F_DELETE  = 4'b1001;

   kv_table #(.KEY_SIZE(96), .TABLE_BITS(4), .AGE_CYCLES(8)) dut (
      .clk156   (clk156),
      .eth_rst  (eth_rst),
      .in_key   (in_key),
      .in_flag  (in_flag),
      .in_valid (in_valid),
      .out_valid(out_valid),
      .out_flag (out_flag),
      .debug    (debug)
   );

   always #5 clk156 = ~clk156;

   task automatic do_reset();
      eth_rst  = 1'b1;
      in_valid = 1'b0;
      in_flag  = 4'b0000;
      in_key   = '0;
      repeat (2) @(posedge clk156);
      #1;
      eth_rst = 1'b0;
   endtask

   // Called one time unit after a rising edge; holds the request for exactly one cycle.
   task automatic req(input logic [95:0] key, input logic [3:0] flag);
      in_key   = key;
      in_flag  = flag;
      in_valid = 1'b1;
      @(posedge clk156);
      #1;
      in_valid = 1'b0;
      in_flag  = 4'b0000;
   endtask

   // lat is counted in cycles from the cycle that carried in_valid.
   task automatic wait_resp(output logic seen, output int lat);
      seen = 1'b0;
      lat  = 0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk156);
         #1;
         if (out_valid) begin
            seen = 1'b1;
            lat  = c + 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic seen;
      int   lat;
      eth_rst  = 1'b1;
      in_valid = 1'b0;
      in_flag  = 4'b0000;
      in_key   = '0;
      repeat (2) @(posedge clk156);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++;
      if (out_flag !== 4'b0000) begin errors++; $display("[TB] FAIL reset_out_flag got=%b want=0000", out_flag); end
      checks++;
      if (debug !== 8'h00) begin errors++; $display("[TB] FAIL reset_debug got=%h want=00", debug); end
      eth_rst = 1'b0;
      req(K, F_SUSPECT);
      wait_resp(seen, lat);
      checks++;
      if (seen !== 1'b1) begin errors++; $display("[TB] FAIL first_after_reset_seen got=%b want=1", seen); end
      checks++;
      if (lat !== 3) begin errors++; $display("[TB] FAIL first_after_reset_latency got=%0d want=3", lat); end
      checks++;
      if (out_flag !== 4'b0010) begin errors++; $display("[TB] FAIL first_after_reset_flag got=%b want=0010", out_flag); end
      @(posedge clk156);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL out_valid_single_pulse got=%b want=0", out_valid); end
   endtask

   task automatic test_suspect_arrest();
      logic seen;
      int   lat;
      do_reset();
      req(K, F_SUSPECT);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0010) begin errors++; $display("[TB] FAIL suspect_miss seen=%b got=%b want=0010", seen, out_flag); end
      req(K, F_SUSPECT);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0011) begin errors++; $display("[TB] FAIL suspect_hit seen=%b got=%b want=0011", seen, out_flag); end
      checks++;
      if (debug[3:0] !== 4'd1) begin errors++; $display("[TB] FAIL hit_cnt_after_suspect got=%0d want=1", debug[3:0]); end
      req(K, F_ARREST);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0101) begin errors++; $display("[TB] FAIL arrest_hit seen=%b got=%b want=0101", seen, out_flag); end
      req(K, F_SUSPECT);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0101) begin errors++; $display("[TB] FAIL suspect_keeps_arrest seen=%b got=%b want=0101", seen, out_flag); end
      checks++;
      if (debug !== 8'h03) begin errors++; $display("[TB] FAIL debug_after_hits got=%h want=03", debug); end
   endtask

   task automatic test_arrest_miss();
      logic seen;
      int   lat;
      do_reset();
      req(K2, F_ARREST);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0000) begin errors++; $display("[TB] FAIL arrest_miss seen=%b got=%b want=0000", seen, out_flag); end
      req(K2, F_QUERY);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0000) begin errors++; $display("[TB] FAIL query_after_arrest_miss seen=%b got=%b want=0000", seen, out_flag); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      in_key   = K;
      in_flag  = F_SUSPECT;
      in_valid = 1'b1;
      @(posedge clk156);
      #1;
      in_flag = F_ARREST;
      @(posedge clk156);
      #1;
      in_valid = 1'b0;
      in_flag  = 4'b0000;
      @(posedge clk156);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_flag !== 4'b0010) begin errors++; $display("[TB] FAIL b2b_first valid=%b got=%b want=0010", out_valid, out_flag); end
      @(posedge clk156);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_flag !== 4'b0101) begin errors++; $display("[TB] FAIL b2b_second_bypass valid=%b got=%b want=0101", out_valid, out_flag); end
      checks++;
      if (debug !== 8'h01) begin errors++; $display("[TB] FAIL b2b_debug got=%h want=01", debug); end
   endtask

   task automatic test_collision();
      logic seen;
      int   lat;
      do_reset();
      req(K, F_SUSPECT);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0010) begin errors++; $display("[TB] FAIL collision_first seen=%b got=%b want=0010", seen, out_flag); end
      req(KC, F_SUSPECT);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0010) begin errors++; $display("[TB] FAIL collision_second seen=%b got=%b want=0010", seen, out_flag); end
      checks++;
      if (debug !== 8'h10) begin errors++; $display("[TB] FAIL collision_debug got=%h want=10", debug); end
      req(K, F_QUERY);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0000) begin errors++; $display("[TB] FAIL collision_query_evicted seen=%b got=%b want=0000", seen, out_flag); end
   endtask

   task automatic test_delete();
      logic seen;
      int   lat;
      do_reset();
      req(K2, F_SUSPECT);
      wait_resp(seen, lat);
      req(K2, 4'b1101);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0001) begin errors++; $display("[TB] FAIL delete_hit seen=%b got=%b want=0001", seen, out_flag); end
      req(K2, F_QUERY);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0000) begin errors++; $display("[TB] FAIL query_after_delete seen=%b got=%b want=0000", seen, out_flag); end
      req(K2, F_DELETE);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0000) begin errors++; $display("[TB] FAIL delete_miss seen=%b got=%b want=0000", seen, out_flag); end
   endtask

   task automatic test_drop();
      logic seen;
      int   lat;
      do_reset();
      req(K, 4'b0010);
      wait_resp(seen, lat);
      checks++;
      if (seen !== 1'b0) begin errors++; $display("[TB] FAIL dropped_request_response got=%b want=0", seen); end
      req(K, F_QUERY);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0000) begin errors++; $display("[TB] FAIL dropped_request_no_insert seen=%b got=%b want=0000", seen, out_flag); end
   endtask

   task automatic test_aging();
      logic seen;
      int   lat;
      do_reset();
      req(K, F_SUSPECT);
      wait_resp(seen, lat);
      repeat (3) @(posedge clk156);
      #1;
      req(K, F_QUERY);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0011) begin errors++; $display("[TB] FAIL aging_young_entry seen=%b got=%b want=0011", seen, out_flag); end
      repeat (20) @(posedge clk156);
      #1;
      req(K, F_QUERY);
      wait_resp(seen, lat);
      checks++;
      if (!seen || out_flag !== 4'b0000) begin errors++; $display("[TB] FAIL aging_evicted seen=%b got=%b want=0000", seen, out_flag); end
   endtask

   task automatic test_reset_midflight();
      logic seen;
      int   lat;
      do_reset();
      req(K, F_SUSPECT);
      eth_rst = 1'b1;
      @(posedge clk156);
      #1;
      eth_rst = 1'b0;
      wait_resp(seen, lat);
      checks++;
      if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midflight_reset_response got=%b want=0", seen); end
   endtask

   initial begin
      eth_rst  = 1'b1;
      in_valid = 1'b0;
      in_flag  = 4'b0000;
      in_key   = '0;
      test_reset();
      test_suspect_arrest();
      test_arrest_miss();
      test_back_to_back();
      test_collision();
      test_delete();
      test_drop();
      test_aging();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/kv_table.md
KV_TABLE -- requirements
Module: kv_table

Interface
REQ-001 Parameter KEY_SIZE, default 96: lookup key width; must be a multiple of 2**TABLE_BITS... no, of TABLE_BITS.
REQ-002 Parameter TABLE_BITS, default 4: log2 of entry count (16 entries, direct-mapped).
REQ-003 Parameter AGE_CYCLES, default 156250000: aging tick period in clk156 cycles (1 s).
REQ-004 clk156  input  1  sole clock; all logic on rising edge.
REQ-005 eth_rst  input  1  reset, synchronous, active-high.
REQ-006 in_key  input  KEY_SIZE  request key {src_ip, dst_ip, dst_port, 16'd0}.
REQ-007 in_flag  input  4  request op: [0] op-enable, [2:1] status op (01 SUSPECT, 10 ARREST, 00 QUERY), [3] delete.
REQ-008 in_valid  input  1  request strobe, one cycle per request; no backpressure.
REQ-009 out_valid  output  1  response strobe, one cycle per accepted request.
REQ-010 out_flag  output  4  response: {1'b0, resulting status[1:0], hit}.
REQ-011 debug  output  8  {collision_cnt[3:0], hit_cnt[3:0]}, both wrapping.

Function
REQ-012 Request accepted when in_valid=1 and in_flag[0]=1; in_valid with in_flag[0]=0 is dropped, no response, no table change.
REQ-013 Entry = {valid, key tag KEY_SIZE bits, status 2 bits, age bit}; 2**TABLE_BITS entries in registers.
REQ-014 Index = XOR fold of in_key into TABLE_BITS-bit slices.
REQ-015 Pipeline: S0 register request and index; S1 read entry, compare tag, hit = valid && tag==key; S2 write-back and drive response; out_valid exactly 3 cycles after accepted in_valid, fully pipelined, one request per cycle.
REQ-016 SUSPECT miss: write entry {1, key, 01, 0}; response {0,01,0}; if overwritten slot was valid with different tag, collision_cnt +1.
REQ-017 SUSPECT hit: status unchanged (ARREST stays ARREST), age cleared; response {0,status,1}.
REQ-018 ARREST hit: status set to 10, age cleared; response {0,10,1}.
REQ-019 ARREST miss: no table change; response {0,00,0}.
REQ-020 QUERY: no table change except age cleared on hit; response {0,status,1} on hit, {0,00,0} on miss.
REQ-021 Delete (in_flag[3]=1) takes precedence over [2:1]: hit invalidates entry, response {0,00,1}; miss response {0,00,0}.
REQ-022 hit_cnt increments on every response with hit=1.
REQ-023 Hazard: S1 read of an index being written by S2 in the same cycle uses the S2 write data (bypass); back-to-back same-key requests see each other's effect in order.
REQ-024 Aging: free-running counter 0..AGE_CYCLES-1; at terminal count, each valid entry with age=1 is invalidated, each valid entry with age=0 gets age=1.
REQ-025 Aging tick coincident with S2 write to the same entry: S2 write wins for that entry; other entries age normally.
REQ-026 Tag compare covers full KEY_SIZE bits; equal index with unequal key is a miss.

Reset
REQ-027 eth_rst=1: all entries invalid, pipeline valid bits 0, out_valid=0, out_flag=0, debug=0, age counter 0.
REQ-028 Reset mid-operation: in-flight requests discarded, no out_valid issued for them after reset deasserts.
REQ-029 First request accepted in the first cycle after eth_rst deasserts.

Verification
REQ-030 SUSPECT key K=96'h0A000001_0A000002_3039_0000 in_flag=4'b0011 -> 3 cycles later out_valid=1, out_flag=4'b0010; repeat -> out_flag=4'b0011, debug[3:0]=1.
REQ-031 After REQ-030, ARREST K in_flag=4'b0101 -> out_flag=4'b0101; then SUSPECT K -> out_flag=4'b0101 (status retained).
REQ-032 ARREST on empty table key K2 -> out_flag=4'b0000; QUERY K2 (4'b0001) -> out_flag=4'b0000.
REQ-033 SUSPECT K then ARREST K on consecutive cycles -> responses 4'b0010 then 4'b0101 on consecutive cycles (bypass).
REQ-034 Two keys with same index, different tags, both SUSPECT -> second response 4'b0010, debug[7:4]=1, QUERY first key -> 4'b0000.
REQ-035 AGE_CYCLES=8, insert K, idle 16+ cycles -> QUERY K returns 4'b0000; assert eth_rst one cycle after an in_valid -> no out_valid follows.
